// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_read;
  logic             kill;
  logic             stall;
  logic             busy;
  logic             hilo_write;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // EX stage side: issues ops, observes stall and the HI/LO write
  modport master (
    output start, op, a, b, hilo_read, kill,
    input  stall, busy, hilo_write, hi_out, lo_out
  );

  // sequencer side
  modport slave (
    input  start, op, a, b, hilo_read, kill,
    output stall, busy, hilo_write, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine that owns arithmetic writes to HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
//
// state | meaning
// IDLE  | waiting for an op; latches operand magnitudes, sign flags and op
// RUN   | one iteration per clock; zero divisor detected on first RUN cycle
// DONE  | result on hi_out/lo_out with a one-cycle hilo_write strobe
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_acc_q, hi_acc_d;
  logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0] hi_out_q, hi_out_d;
  logic [WIDTH-1:0] lo_out_q, lo_out_d;
  logic             hilo_write_q, hilo_write_d;

  logic             start_go;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] iter_hi, iter_lo, fix_hi, fix_lo, div0_hi;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic             is_signed_q, neg_res, neg_rem;

  // a kill in the same cycle cancels the issue
  assign start_go = bus.start & ~bus.kill;

  // signed ops iterate on magnitudes; the sign is restored in the fix-up
  assign in_a_mag = (~bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign in_b_mag = (~bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign is_signed_q = ~op_q[0];
  assign neg_res     = is_signed_q & (sa_q ^ sb_q);
  assign neg_rem     = is_signed_q & sa_q;

  // one arithmetic step plus the sign fix-up of the final step
  always_comb begin
    mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ge    = ~div_diff[WIDTH+1];
    if (op_q[1]) begin
      iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {lo_acc_q[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end
    prod     = {iter_hi, iter_lo};
    prod_fix = neg_res ? -prod : prod;
    if (op_q[1]) begin
      fix_hi = neg_rem ? -iter_hi : iter_hi;
      fix_lo = neg_res ? -iter_lo : iter_lo;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
    // lo_acc still holds |A| on the first RUN cycle, so undo the magnitude
    div0_hi = neg_rem ? -lo_acc_q : lo_acc_q;
  end

  // next-state and datapath update
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    b_d          = b_q;
    hi_acc_d     = hi_acc_q;
    lo_acc_d     = lo_acc_q;
    hi_out_d     = hi_out_q;
    lo_out_d     = lo_out_q;
    hilo_write_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          op_d     = bus.op;
          sa_d     = bus.a[WIDTH-1];
          sb_d     = bus.b[WIDTH-1];
          b_d      = in_b_mag;
          hi_acc_d = '0;
          lo_acc_d = in_a_mag;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (op_q[1] && (b_q == '0)) begin
          hi_out_d     = div0_hi;
          lo_out_d     = '1;
          hilo_write_d = 1'b1;
          state_d      = DONE;
        end else begin
          hi_acc_d = iter_hi;
          lo_acc_d = iter_lo;
          count_d  = count_q + 1'b1;
          if (count_q == LAST) begin
            hi_out_d     = fix_hi;
            lo_out_d     = fix_lo;
            hilo_write_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // all sequencer state, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      op_q         <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      b_q          <= '0;
      hi_acc_q     <= '0;
      lo_acc_q     <= '0;
      hi_out_q     <= '0;
      lo_out_q     <= '0;
      hilo_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      b_q          <= b_d;
      hi_acc_q     <= hi_acc_d;
      lo_acc_q     <= lo_acc_d;
      hi_out_q     <= hi_out_d;
      lo_out_q     <= lo_out_d;
      hilo_write_q <= hilo_write_d;
    end
  end

  // MFHI/MFLO in EX waits while a result is pending; RUN already stalls,
  // the read term just keeps that dependency visible
  assign bus.stall      = ((state_q == IDLE) & start_go) | (state_q == RUN)
                        | (bus.hilo_read & (state_q == RUN));
  assign bus.busy       = (state_q != IDLE);
  assign bus.hilo_write = hilo_write_q;
  assign bus.hi_out     = hi_out_q;
  assign bus.lo_out     = lo_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_muldiv_sequencer;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // reference results from plain arithmetic
  task automatic model(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sp;
    logic [63:0] up;
    int ia, ib;
    ia = av;
    ib = bv;
    eh = '0;
    el = '0;
    case (op)
      2'b00: begin
        sp = longint'(ia) * longint'(ib);
        up = sp;
        eh = up[63:32];
        el = up[31:0];
      end
      2'b01: begin
        up = {32'b0, av} * {32'b0, bv};
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (bv == 32'h0) begin
          eh = av;
          el = 32'hFFFF_FFFF;
        end else if (op == 2'b10 && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          eh = 32'h0;
          el = 32'h8000_0000;
        end else if (op == 2'b10) begin
          el = ia / ib;
          eh = ia % ib;
        end else begin
          el = av / bv;
          eh = av % bv;
        end
      end
    endcase
  endtask

  // runs one op cycle-by-cycle; cycle 0 is the cycle start is presented
  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int kill_cyc, input int rd_cyc, input int restart_cyc);
    logic [31:0] eh, el;
    int done_cyc, last_cyc;
    bit killed;
    logic e_stall, e_busy, e_wr;
    logic [31:0] e_hi, e_lo;
    model(op, av, bv, eh, el);
    done_cyc = (op[1] && bv == 32'h0) ? 2 : 33;
    killed   = (kill_cyc >= 1) && (kill_cyc < done_cyc);
    last_cyc = killed ? kill_cyc + 1 : done_cyc + 1;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == 0) || (cyc == restart_cyc);
      bus.op    = op;
      if (cyc == 0) begin
        bus.a = av;
        bus.b = bv;
      end else begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      bus.kill      = (cyc == kill_cyc);
      bus.hilo_read = (rd_cyc >= 0) && (cyc >= rd_cyc);
      #1;
      e_hi = last_hi;
      e_lo = last_lo;
      if (cyc == last_cyc) begin
        e_stall = 1'b0; e_busy = 1'b0; e_wr = 1'b0;
      end else if (!killed && cyc == done_cyc) begin
        e_stall = 1'b0; e_busy = 1'b1; e_wr = 1'b1;
        e_hi = eh; e_lo = el;
      end else begin
        e_stall = 1'b1; e_busy = (cyc != 0); e_wr = 1'b0;
      end
      chk("stall", cyc, {31'b0, bus.stall}, {31'b0, e_stall});
      chk("busy", cyc, {31'b0, bus.busy}, {31'b0, e_busy});
      chk("hilo_write", cyc, {31'b0, bus.hilo_write}, {31'b0, e_wr});
      chk("hi_out", cyc, bus.hi_out, e_hi);
      chk("lo_out", cyc, bus.lo_out, e_lo);
      if (e_wr) begin
        last_hi = eh;
        last_lo = el;
      end
    end
    bus.start     = 1'b0;
    bus.kill      = 1'b0;
    bus.hilo_read = 1'b0;
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    int rk, rr, rs;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hilo_read = 1'b0; bus.kill = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", 0, {31'b0, bus.stall}, 32'h0);
    chk("rst_busy", 0, {31'b0, bus.busy}, 32'h0);
    chk("rst_wr", 0, {31'b0, bus.hilo_write}, 32'h0);
    chk("rst_hi", 0, bus.hi_out, 32'h0);
    chk("rst_lo", 0, bus.lo_out, 32'h0);
    rst = 1'b0;

    // MULTU max operands; stall windows and latency checked inside run_op
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    chk("t1_hi", 0, bus.hi_out, 32'hFFFF_FFFE);
    chk("t1_lo", 0, bus.lo_out, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd6, -1, -1, -1);
    chk("t2_hi", 0, bus.hi_out, 32'hFFFF_FFFF);
    chk("t2_lo", 0, bus.lo_out, 32'hFFFF_FFD6);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    chk("t3_hi", 0, bus.hi_out, 32'hFFFF_FFFF);
    chk("t3_lo", 0, bus.lo_out, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, -1, -1, -1);
    chk("t3u_lo", 0, bus.lo_out, 32'd14);
    chk("t3u_hi", 0, bus.hi_out, 32'd2);
    run_op(2'b11, 32'h1234, 32'h0, -1, -1, -1);
    chk("t4_hi", 0, bus.hi_out, 32'h1234);
    chk("t4_lo", 0, bus.lo_out, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FF00, 32'h0, -1, -1, -1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    chk("t4o_lo", 0, bus.lo_out, 32'h8000_0000);
    chk("t4o_hi", 0, bus.hi_out, 32'h0);
    // kill mid-run, kill in DONE, hilo_read wait, restart during RUN
    run_op(2'b00, 32'd12345, 32'hFFFF_0001, 10, -1, -1);
    run_op(2'b10, 32'd77, 32'd5, 33, -1, -1);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, -1, 3, 12);
    run_op(2'b10, 32'd9, 32'h0, 1, -1, -1);

    // start together with kill in IDLE does nothing
    @(posedge clk); #1;
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    #1;
    chk("sk_stall", 0, {31'b0, bus.stall}, 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.hilo_read = 1'b1;
    #1;
    chk("sk_busy", 1, {31'b0, bus.busy}, 32'h0);
    chk("idle_read_stall", 1, {31'b0, bus.stall}, 32'h0);
    bus.hilo_read = 1'b0;

    // reset at cycle 5 of a DIV
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (cyc == 5) rst = 1'b1;
    end
    @(posedge clk); #2;
    chk("rmid_busy", 6, {31'b0, bus.busy}, 32'h0);
    chk("rmid_stall", 6, {31'b0, bus.stall}, 32'h0);
    chk("rmid_wr", 6, {31'b0, bus.hilo_write}, 32'h0);
    chk("rmid_hi", 6, bus.hi_out, 32'h0);
    chk("rmid_lo", 6, bus.lo_out, 32'h0);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    for (int cyc = 7; cyc < 45; cyc++) begin
      @(posedge clk); #2;
      chk("rmid_nowr", cyc, {31'b0, bus.hilo_write}, 32'h0);
    end

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      rk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : -1;
      rr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_op(rop, ra, rb, rk, rr, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
